dsp38_mac_sequencer: RTL and testbench

Initiator-side controller for a DSP38 configured as `DSP_MODE="MULTIPLY_ACCUMULATE"`. It accepts a dot-product job (length, sign and control options), streams operand pairs into the DSP38 control and data ports, and drains the DSP pipeline. It then captures `Z` and returns it on a valid/ready result port. The parent instantiates the sequencer beside a DSP38 and passes it the same `INPUT_REG_EN` and `OUTPUT_REG_EN` strings.

---
 rtl/dsp38_mac_sequencer_pkg.sv | 21 ++
 rtl/dsp38_mac_sequencer_if.sv | 63 ++++++
 rtl/dsp38_mac_sequencer.sv | 179 +++++++++++++++++
 tb/tb_dsp38_mac_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp38_mac_sequencer_pkg.sv
// Shared types and constants for the DSP38 multiply-accumulate sequencer.
package dsp38_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    HOLD
  } seq_state_e;

  localparam int unsigned A_W     = 20;
  localparam int unsigned B_W     = 18;
  localparam int unsigned Z_W     = 38;
  localparam int unsigned SHIFT_W = 6;

  // Edges from the DSP_A/B update to a settled Z, matching the DSP38 register options.
  function automatic int unsigned seq_latency(input bit in_en, input bit out_en);
    return 1 + (in_en ? 1 : 0) + (out_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/dsp38_mac_sequencer_if.sv
// Job, operand, result and DSP38-side signals of the MAC sequencer.
interface dsp38_mac_sequencer_if;
  import dsp38_seq_pkg::*;

  logic               JOB_VALID;
  logic               JOB_READY;
  logic [7:0]         JOB_LEN;
  logic               JOB_SUB;
  logic               JOB_SAT;
  logic               JOB_UNSIGNED_A;
  logic               JOB_UNSIGNED_B;
  logic [SHIFT_W-1:0] JOB_SHIFT;
  logic               JOB_ROUND;

  logic               OP_VALID;
  logic               OP_READY;
  logic [A_W-1:0]     OP_A;
  logic [B_W-1:0]     OP_B;

  logic               RES_VALID;
  logic               RES_READY;
  logic [Z_W-1:0]     RES_Z;

  logic [A_W-1:0]     DSP_A;
  logic [B_W-1:0]     DSP_B;
  logic               DSP_LOAD_ACC;
  logic               DSP_SUBTRACT;
  logic               DSP_SATURATE;
  logic               DSP_ROUND;
  logic               DSP_UNSIGNED_A;
  logic               DSP_UNSIGNED_B;
  logic               DSP_RESET;
  logic [SHIFT_W-1:0] DSP_SHIFT_RIGHT;
  logic [2:0]         DSP_FEEDBACK;
  logic [Z_W-1:0]     DSP_Z;

  modport master (
    output JOB_VALID, JOB_LEN, JOB_SUB, JOB_SAT, JOB_UNSIGNED_A, JOB_UNSIGNED_B,
           JOB_SHIFT, JOB_ROUND,
    input  JOB_READY,
    output OP_VALID, OP_A, OP_B,
    input  OP_READY,
    input  RES_VALID, RES_Z,
    output RES_READY,
    input  DSP_A, DSP_B, DSP_LOAD_ACC, DSP_SUBTRACT, DSP_SATURATE, DSP_ROUND,
           DSP_UNSIGNED_A, DSP_UNSIGNED_B, DSP_RESET, DSP_SHIFT_RIGHT, DSP_FEEDBACK,
    output DSP_Z
  );

  modport slave (
    input  JOB_VALID, JOB_LEN, JOB_SUB, JOB_SAT, JOB_UNSIGNED_A, JOB_UNSIGNED_B,
           JOB_SHIFT, JOB_ROUND,
    output JOB_READY,
    input  OP_VALID, OP_A, OP_B,
    output OP_READY,
    output RES_VALID, RES_Z,
    input  RES_READY,
    output DSP_A, DSP_B, DSP_LOAD_ACC, DSP_SUBTRACT, DSP_SATURATE, DSP_ROUND,
           DSP_UNSIGNED_A, DSP_UNSIGNED_B, DSP_RESET, DSP_SHIFT_RIGHT, DSP_FEEDBACK,
    input  DSP_Z
  );

endinterface

// File: rtl/dsp38_mac_sequencer.sv
// Streams a dot-product job into a DSP38 in MULTIPLY_ACCUMULATE mode and returns Z.
// Optional macro DSP38_SEQ_ROUND_EN forwards JOB_SHIFT/JOB_ROUND to the DSP38.
module dsp38_mac_sequencer
  import dsp38_seq_pkg::*;
#(
  parameter string INPUT_REG_EN  = "FALSE",
  parameter string OUTPUT_REG_EN = "FALSE"
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  dsp38_mac_sequencer_if.slave bus
);

  localparam int unsigned LAT        = seq_latency(INPUT_REG_EN == "TRUE", OUTPUT_REG_EN == "TRUE");
  localparam logic [1:0]  DRAIN_INIT = 2'(LAT);

  seq_state_e     state_q, state_d;
  logic [8:0]     remaining_q, remaining_d;
  logic [8:0]     accepted_q, accepted_d;
  logic [1:0]     drain_q, drain_d;
  logic           sub_q, sub_d;
  logic           sat_q, sat_d;
  logic           ua_q, ua_d;
  logic           ub_q, ub_d;
  logic [A_W-1:0] dsp_a_q, dsp_a_d;
  logic [B_W-1:0] dsp_b_q, dsp_b_d;
  logic           load_acc_q, load_acc_d;
  logic           dsp_reset_q, dsp_reset_d;
  logic           res_valid_q, res_valid_d;
  logic [Z_W-1:0] res_z_q, res_z_d;
`ifdef DSP38_SEQ_ROUND_EN
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               round_q, round_d;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    accepted_d  = accepted_q;
    drain_d     = drain_q;
    sub_d       = sub_q;
    sat_d       = sat_q;
    ua_d        = ua_q;
    ub_d        = ub_q;
    dsp_a_d     = '0;
    dsp_b_d     = '0;
    load_acc_d  = load_acc_q;
    dsp_reset_d = dsp_reset_q;
    res_valid_d = res_valid_q;
    res_z_d     = res_z_q;
`ifdef DSP38_SEQ_ROUND_EN
    shift_d     = shift_q;
    round_d     = round_q;
`endif

    unique case (state_q)
      IDLE: begin
        dsp_reset_d = 1'b1;
        load_acc_d  = 1'b0;
        if (bus.JOB_VALID) begin
          sub_d       = bus.JOB_SUB;
          sat_d       = bus.JOB_SAT;
          ua_d        = bus.JOB_UNSIGNED_A;
          ub_d        = bus.JOB_UNSIGNED_B;
`ifdef DSP38_SEQ_ROUND_EN
          shift_d     = bus.JOB_SHIFT;
          round_d     = bus.JOB_ROUND;
`endif
          remaining_d = (bus.JOB_LEN == '0) ? 9'd256 : {1'b0, bus.JOB_LEN};
          accepted_d  = '0;
          dsp_reset_d = 1'b0;
          state_d     = FEED;
        end
      end

      FEED: begin
        // Bubbles feed zero operands, so accumulating through them leaves the sum intact.
        load_acc_d = (accepted_q != '0);
        if (bus.OP_VALID) begin
          dsp_a_d     = bus.OP_A;
          dsp_b_d     = bus.OP_B;
          accepted_d  = accepted_q + 9'd1;
          remaining_d = remaining_q - 9'd1;
          if (remaining_q == 9'd1) begin
            drain_d = DRAIN_INIT;
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        load_acc_d = 1'b1;
        if (drain_q == '0) begin
          res_z_d     = bus.DSP_Z;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end

      HOLD: begin
        load_acc_d = 1'b1;
        if (bus.RES_READY) begin
          res_valid_d = 1'b0;
          dsp_reset_d = 1'b1;
          load_acc_d  = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      accepted_q  <= '0;
      drain_q     <= '0;
      sub_q       <= 1'b0;
      sat_q       <= 1'b0;
      ua_q        <= 1'b1;
      ub_q        <= 1'b1;
      dsp_a_q     <= '0;
      dsp_b_q     <= '0;
      load_acc_q  <= 1'b0;
      dsp_reset_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_z_q     <= '0;
`ifdef DSP38_SEQ_ROUND_EN
      shift_q     <= '0;
      round_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      accepted_q  <= accepted_d;
      drain_q     <= drain_d;
      sub_q       <= sub_d;
      sat_q       <= sat_d;
      ua_q        <= ua_d;
      ub_q        <= ub_d;
      dsp_a_q     <= dsp_a_d;
      dsp_b_q     <= dsp_b_d;
      load_acc_q  <= load_acc_d;
      dsp_reset_q <= dsp_reset_d;
      res_valid_q <= res_valid_d;
      res_z_q     <= res_z_d;
`ifdef DSP38_SEQ_ROUND_EN
      shift_q     <= shift_d;
      round_q     <= round_d;
`endif
    end
  end

  assign bus.JOB_READY      = (state_q == IDLE);
  assign bus.OP_READY       = (state_q == FEED);
  assign bus.RES_VALID      = res_valid_q;
  assign bus.RES_Z          = res_z_q;
  assign bus.DSP_A          = dsp_a_q;
  assign bus.DSP_B          = dsp_b_q;
  assign bus.DSP_LOAD_ACC   = load_acc_q;
  assign bus.DSP_SUBTRACT   = sub_q;
  assign bus.DSP_SATURATE   = sat_q;
  assign bus.DSP_UNSIGNED_A = ua_q;
  assign bus.DSP_UNSIGNED_B = ub_q;
  assign bus.DSP_RESET      = dsp_reset_q;
  assign bus.DSP_FEEDBACK   = '0;
`ifdef DSP38_SEQ_ROUND_EN
  assign bus.DSP_SHIFT_RIGHT = shift_q;
  assign bus.DSP_ROUND       = round_q;
`else
  assign bus.DSP_SHIFT_RIGHT = '0;
  assign bus.DSP_ROUND       = 1'b0;
`endif

endmodule

// File: tb/tb_dsp38_mac_sequencer.sv
// Bench for dsp38_mac_sequencer: two instances (no DSP registers / both DSP registers) beside DSP38 models.
module tb_dsp38_mac_sequencer;

  logic  CLK = 1'b0;
  logic  RESET_N = 1'b0;
  longint cyc = 0;
  int    errors = 0;
  int    checks = 0;

  localparam longint ZMAX = (longint'(1) <<< 37) - 1;
  localparam longint ZMIN = -(longint'(1) <<< 37);

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  dsp38_mac_sequencer_if b0 ();
  dsp38_mac_sequencer_if b1 ();

  dsp38_mac_sequencer #(.INPUT_REG_EN("FALSE"), .OUTPUT_REG_EN("FALSE")) u0 (
    .CLK(CLK), .RESET_N(RESET_N), .bus(b0));
  dsp38_mac_sequencer #(.INPUT_REG_EN("TRUE"), .OUTPUT_REG_EN("TRUE")) u1 (
    .CLK(CLK), .RESET_N(RESET_N), .bus(b1));

  // DSP38 MULTIPLY_ACCUMULATE behaviour used by the two models and the reference.
  function automatic longint prod(input logic [19:0] a, input logic [17:0] b, input logic ua, input logic ub);
    longint sa, sb;
    sa = ua ? longint'(a) : longint'($signed(a));
    sb = ub ? longint'(b) : longint'($signed(b));
    return sa * sb;
  endfunction

  function automatic longint acc_next(input longint acc, input logic load, input logic sub, input longint p);
    longint base;
    base = load ? acc : 64'sd0;
    return sub ? base - p : base + p;
  endfunction

  function automatic logic [37:0] z_of(input longint acc, input logic [5:0] sh, input logic rnd, input logic sat);
    longint v;
    v = acc;
    if (rnd && sh != 6'd0) v = v + (longint'(1) <<< (sh - 6'd1));
    v = v >>> sh;
    if (sat && v > ZMAX) v = ZMAX;
    if (sat && v < ZMIN) v = ZMIN;
    return 38'(v);
  endfunction

  // Model for instance 0: no input or output registers.
  longint acc0 = 0;
  always @(posedge CLK) begin
    if (b0.DSP_RESET) acc0 <= 0;
    else acc0 <= acc_next(acc0, b0.DSP_LOAD_ACC, b0.DSP_SUBTRACT,
                          prod(b0.DSP_A, b0.DSP_B, b0.DSP_UNSIGNED_A, b0.DSP_UNSIGNED_B));
  end
  assign b0.DSP_Z = z_of(acc0, b0.DSP_SHIFT_RIGHT, b0.DSP_ROUND, b0.DSP_SATURATE);

  // Model for instance 1: input and output registers.
  logic [19:0] a1r = '0;
  logic [17:0] b1r = '0;
  logic        ld1r = 1'b0, sub1r = 1'b0, ua1r = 1'b0, ub1r = 1'b0;
  longint      acc1 = 0;
  logic [37:0] z1q = '0;
  always @(posedge CLK) begin
    if (b1.DSP_RESET) begin
      a1r <= '0; b1r <= '0; ld1r <= 1'b0; sub1r <= 1'b0; ua1r <= 1'b0; ub1r <= 1'b0;
      acc1 <= 0; z1q <= '0;
    end else begin
      a1r <= b1.DSP_A; b1r <= b1.DSP_B; ld1r <= b1.DSP_LOAD_ACC; sub1r <= b1.DSP_SUBTRACT;
      ua1r <= b1.DSP_UNSIGNED_A; ub1r <= b1.DSP_UNSIGNED_B;
      acc1 <= acc_next(acc1, ld1r, sub1r, prod(a1r, b1r, ua1r, ub1r));
      z1q  <= z_of(acc1, b1.DSP_SHIFT_RIGHT, b1.DSP_ROUND, b1.DSP_SATURATE);
    end
  end
  assign b1.DSP_Z = z1q;

  // Current job description and scoreboards.
  logic [7:0]  j_len;
  logic        j_sub, j_sat, j_ua, j_ub, j_round;
  logic [5:0]  j_shift;
  logic [19:0] qa[$];
  logic [17:0] qb[$];
  int unsigned qgap[$];
  logic [37:0] exp0[$];
  logic [37:0] exp1[$];

  function automatic logic [37:0] ref_result();
    longint acc;
    acc = 0;
    foreach (qa[i]) begin
      if (j_sub) acc = acc - prod(qa[i], qb[i], j_ua, j_ub);
      else       acc = acc + prod(qa[i], qb[i], j_ua, j_ub);
    end
`ifdef DSP38_SEQ_ROUND_EN
    return z_of(acc, j_shift, j_round, j_sat);
`else
    return z_of(acc, 6'd0, 1'b0, j_sat);
`endif
  endfunction

  task automatic set_job(input logic [7:0] len, input logic sub, input logic sat, input logic ua,
                         input logic ub, input logic [5:0] sh, input logic rnd);
    j_len = len; j_sub = sub; j_sat = sat; j_ua = ua; j_ub = ub; j_shift = sh; j_round = rnd;
    qa.delete(); qb.delete(); qgap.delete();
  endtask

  task automatic add_op(input logic [19:0] a, input logic [17:0] b, input int unsigned gap);
    qa.push_back(a); qb.push_back(b); qgap.push_back(gap);
  endtask

  task automatic drive_job(input logic v);
    b0.JOB_VALID = v; b0.JOB_LEN = j_len; b0.JOB_SUB = j_sub; b0.JOB_SAT = j_sat;
    b0.JOB_UNSIGNED_A = j_ua; b0.JOB_UNSIGNED_B = j_ub; b0.JOB_SHIFT = j_shift; b0.JOB_ROUND = j_round;
    b1.JOB_VALID = v; b1.JOB_LEN = j_len; b1.JOB_SUB = j_sub; b1.JOB_SAT = j_sat;
    b1.JOB_UNSIGNED_A = j_ua; b1.JOB_UNSIGNED_B = j_ub; b1.JOB_SHIFT = j_shift; b1.JOB_ROUND = j_round;
  endtask

  task automatic set_op(input logic v, input logic [19:0] a, input logic [17:0] b);
    b0.OP_VALID = v; b0.OP_A = a; b0.OP_B = b;
    b1.OP_VALID = v; b1.OP_A = a; b1.OP_B = b;
  endtask

  task automatic start_job(input bit push);
    int unsigned n;
    if (push) begin
      exp0.push_back(ref_result());
      exp1.push_back(ref_result());
    end
    drive_job(1'b1);
    n = 0;
    while (!(b0.JOB_READY && b1.JOB_READY) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!(b0.JOB_READY && b1.JOB_READY))
      $display("FAIL job_accept: JOB_READY=%b/%b required 1/1", b0.JOB_READY, b1.JOB_READY);
    @(negedge CLK);
    drive_job(1'b0);
  endtask

  task automatic feed_ops(output longint last_cyc);
    int unsigned n;
    last_cyc = cyc;
    foreach (qa[i]) begin
      for (int unsigned g = 0; g < qgap[i]; g++) begin
        set_op(1'b0, '0, '0);
        @(negedge CLK);
        checks++;
        if (b0.DSP_LOAD_ACC !== (i != 0) || b0.DSP_A !== '0 || b1.DSP_LOAD_ACC !== (i != 0))
          $display("FAIL bubble[%0d]: LOAD_ACC=%b/%b A=%h required LOAD_ACC=%b A=0",
                   i, b0.DSP_LOAD_ACC, b1.DSP_LOAD_ACC, b0.DSP_A, (i != 0));
      end
      set_op(1'b1, qa[i], qb[i]);
      n = 0;
      while (!(b0.OP_READY && b1.OP_READY) && n < 20) begin
        @(negedge CLK);
        n++;
      end
      if (!(b0.OP_READY && b1.OP_READY)) begin
        errors++; checks++;
        $display("FAIL op_ready[%0d]: OP_READY=%b/%b required 1/1", i, b0.OP_READY, b1.OP_READY);
        set_op(1'b0, '0, '0);
        return;
      end
      @(negedge CLK);
      last_cyc = cyc;
      checks++;
      if (b0.DSP_A !== qa[i] || b1.DSP_B !== qb[i] || b0.DSP_LOAD_ACC !== (i != 0) || b1.DSP_LOAD_ACC !== (i != 0)) begin
        errors++;
        $display("FAIL accept[%0d]: A=%h B=%h LOAD_ACC=%b/%b required A=%h B=%h LOAD_ACC=%b",
                 i, b0.DSP_A, b1.DSP_B, b0.DSP_LOAD_ACC, b1.DSP_LOAD_ACC, qa[i], qb[i], (i != 0));
      end
    end
    set_op(1'b0, '0, '0);
  endtask

  task automatic collect(input string name, input longint last_cyc, input int unsigned hold);
    bit s0, s1;
    int unsigned l0, l1;
    logic [37:0] e0, e1, z0, z1;
    s0 = 0; s1 = 0; l0 = 0; l1 = 0;
    for (int k = 0; k < 40 && !(s0 && s1); k++) begin
      if (!s0 && b0.RES_VALID) begin s0 = 1; l0 = int'(cyc - last_cyc); end
      if (!s1 && b1.RES_VALID) begin s1 = 1; l1 = int'(cyc - last_cyc); end
      if (!(s0 && s1)) @(negedge CLK);
    end
    e0 = (exp0.size() > 0) ? exp0.pop_front() : 38'h0;
    e1 = (exp1.size() > 0) ? exp1.pop_front() : 38'h0;
    checks++;
    if (!s0 || l0 != 2) begin
      errors++;
      $display("FAIL %s latency_L1: seen=%0d after %0d edges required 2", name, s0, l0);
    end
    checks++;
    if (!s1 || l1 != 4) begin
      errors++;
      $display("FAIL %s latency_L3: seen=%0d after %0d edges required 4", name, s1, l1);
    end
    checks++;
    if (b0.RES_Z !== e0) begin
      errors++;
      $display("FAIL %s res_z_L1: got %0d required %0d", name, $signed(b0.RES_Z), $signed(e0));
    end
    checks++;
    if (b1.RES_Z !== e1) begin
      errors++;
      $display("FAIL %s res_z_L3: got %0d required %0d", name, $signed(b1.RES_Z), $signed(e1));
    end
    z0 = b0.RES_Z; z1 = b1.RES_Z;
    if (hold > 0) drive_job(1'b1);
    for (int unsigned h = 0; h < hold; h++) begin
      @(negedge CLK);
      checks++;
      if (b0.RES_VALID !== 1'b1 || b1.RES_VALID !== 1'b1 || b0.RES_Z !== z0 || b1.RES_Z !== z1 ||
          b0.JOB_READY !== 1'b0 || b1.JOB_READY !== 1'b0 || b0.OP_READY !== 1'b0) begin
        errors++;
        $display("FAIL %s hold[%0d]: VALID=%b/%b Z=%h/%h JOB_READY=%b/%b required 1/1 %h/%h 0/0",
                 name, h, b0.RES_VALID, b1.RES_VALID, b0.RES_Z, b1.RES_Z, b0.JOB_READY, b1.JOB_READY, z0, z1);
      end
    end
    drive_job(1'b0);
    b0.RES_READY = 1'b1; b1.RES_READY = 1'b1;
    @(negedge CLK);
    b0.RES_READY = 1'b0; b1.RES_READY = 1'b0;
    checks++;
    if (b0.RES_VALID !== 1'b0 || b1.RES_VALID !== 1'b0 || b0.JOB_READY !== 1'b1 ||
        b1.JOB_READY !== 1'b1 || b0.DSP_RESET !== 1'b1) begin
      errors++;
      $display("FAIL %s release: VALID=%b/%b JOB_READY=%b/%b DSP_RESET=%b required 0/0 1/1 1",
               name, b0.RES_VALID, b1.RES_VALID, b0.JOB_READY, b1.JOB_READY, b0.DSP_RESET);
    end
  endtask

  task automatic run_job(input string name, input int unsigned hold);
    longint last;
    start_job(1'b1);
    feed_ops(last);
    checks++;
    if (b0.OP_READY !== 1'b0 || b1.OP_READY !== 1'b0) begin
      errors++;
      $display("FAIL %s feed_done: OP_READY=%b/%b required 0/0", name, b0.OP_READY, b1.OP_READY);
    end
    collect(name, last, hold);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (b0.RES_VALID !== 1'b0 || b1.RES_VALID !== 1'b0 || b0.DSP_RESET !== 1'b1 || b1.DSP_RESET !== 1'b1 ||
        b0.JOB_READY !== 1'b1 || b1.JOB_READY !== 1'b1 || b0.OP_READY !== 1'b0 || b0.DSP_LOAD_ACC !== 1'b0) begin
      errors++;
      $display("FAIL %s: VALID=%b/%b DSP_RESET=%b/%b JOB_READY=%b/%b OP_READY=%b LOAD=%b required 0/0 1/1 1/1 0 0",
               name, b0.RES_VALID, b1.RES_VALID, b0.DSP_RESET, b1.DSP_RESET, b0.JOB_READY, b1.JOB_READY,
               b0.OP_READY, b0.DSP_LOAD_ACC);
    end
  endtask

  task automatic test_reset();
    check_idle("reset_state");
    checks++;
    if (b0.RES_Z !== '0 || b1.RES_Z !== '0 || b0.DSP_A !== '0 || b0.DSP_B !== '0 || b0.DSP_SUBTRACT !== 1'b0 ||
        b0.DSP_SATURATE !== 1'b0 || b0.DSP_ROUND !== 1'b0 || b0.DSP_SHIFT_RIGHT !== '0 || b0.DSP_FEEDBACK !== '0) begin
      errors++;
      $display("FAIL reset_zero: Z=%h A=%h B=%h SUB=%b SAT=%b RND=%b SH=%h FB=%h required all 0",
               b0.RES_Z, b0.DSP_A, b0.DSP_B, b0.DSP_SUBTRACT, b0.DSP_SATURATE, b0.DSP_ROUND,
               b0.DSP_SHIFT_RIGHT, b0.DSP_FEEDBACK);
    end
    checks++;
    if (b0.DSP_UNSIGNED_A !== 1'b1 || b0.DSP_UNSIGNED_B !== 1'b1 || b1.DSP_UNSIGNED_A !== 1'b1) begin
      errors++;
      $display("FAIL reset_unsigned: UA=%b UB=%b required 1 1", b0.DSP_UNSIGNED_A, b0.DSP_UNSIGNED_B);
    end
  endtask

  task automatic test_unsigned_dot();
    set_job(8'd3, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0);
    repeat (3) add_op(20'd3, 18'd1, 0);
    run_job("unsigned_dot", 0);
  endtask

  task automatic test_bubbles();
    set_job(8'd2, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0);
    add_op(20'd3, 18'd2, 1);
    add_op(20'd3, 18'd2, 2);
    run_job("bubbles", 0);
  endtask

  task automatic test_signed_sub();
    longint last;
    set_job(8'd2, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
    add_op(20'hFFFFD, 18'd2, 0);
    add_op(20'd1, 18'd2, 0);
    start_job(1'b1);
    checks++;
    if (b0.DSP_SUBTRACT !== 1'b1 || b0.DSP_UNSIGNED_A !== 1'b0 || b1.DSP_UNSIGNED_B !== 1'b1) begin
      errors++;
      $display("FAIL signed_ctrl: SUB=%b UA=%b UB=%b required 1 0 1",
               b0.DSP_SUBTRACT, b0.DSP_UNSIGNED_A, b1.DSP_UNSIGNED_B);
    end
    feed_ops(last);
    collect("signed_sub", last, 0);
  endtask

  task automatic test_round();
    longint last;
    logic [5:0] sh_exp;
    logic       rnd_exp;
`ifdef DSP38_SEQ_ROUND_EN
    sh_exp = 6'd1; rnd_exp = 1'b1;
`else
    sh_exp = 6'd0; rnd_exp = 1'b0;
`endif
    set_job(8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd1, 1'b1);
    add_op(20'd3, 18'd1, 0);
    start_job(1'b1);
    checks++;
    if (b0.DSP_SHIFT_RIGHT !== sh_exp || b0.DSP_ROUND !== rnd_exp || b1.DSP_SHIFT_RIGHT !== sh_exp) begin
      errors++;
      $display("FAIL round_ctrl: SH=%0d RND=%b required %0d %b", b0.DSP_SHIFT_RIGHT, b0.DSP_ROUND, sh_exp, rnd_exp);
    end
    feed_ops(last);
    collect("round_len1", last, 0);
  endtask

  task automatic test_len256();
    set_job(8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0);
    for (int i = 0; i < 256; i++) add_op(20'd1, 18'd1, 0);
    run_job("len256", 0);
  endtask

  task automatic test_backpressure();
    set_job(8'd2, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0);
    add_op(20'd7, 18'd5, 0);
    add_op(20'd2, 18'd3, 0);
    run_job("backpressure", 5);
  endtask

  task automatic test_reset_mid();
    longint last;
    set_job(8'd4, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0);
    add_op(20'd9, 18'd9, 0);
    add_op(20'd9, 18'd9, 0);
    start_job(1'b0);
    feed_ops(last);
    RESET_N = 1'b0;
    #1;
    check_idle("reset_mid");
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    set_job(8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0);
    add_op(20'd2, 18'd5, 0);
    run_job("after_reset", 0);
  endtask

  initial begin
    drive_job(1'b0);
    set_op(1'b0, '0, '0);
    j_len = '0; j_sub = 0; j_sat = 0; j_ua = 1; j_ub = 1; j_shift = '0; j_round = 0;
    drive_job(1'b0);
    b0.RES_READY = 1'b0; b1.RES_READY = 1'b0;
    repeat (3) @(negedge CLK);
    test_reset();
    RESET_N = 1'b1;
    @(negedge CLK);
    test_unsigned_dot();
    test_bubbles();
    test_signed_sub();
    test_round();
    test_len256();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
